dot_acc_drain: RTL and testbench
================================

# dot_acc_drain

Output-side controller for a `dot16_dsp`-style dot-product pipeline. It issues the `ena` strobe to the dot unit and tags each issued operand slice through a shadow pipeline. It accumulates the signed partial dot products of successive K-slices into one wide result per output element, then delivers finished results through a small FIFO with a valid/ready handshake. It sits between the PE operand feeder (upstream) and the PE result writer (downstream). Credit-based flow control means no result is ever dropped or stalled inside the dot pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 8: operand width of the dot unit. Partial result width is `DATA_WIDTH*2+4`.
- `DOT_LATENCY`, 1: number of enabled clock edges from operand presentation to valid `dot_res`. Minimum 1.
- `ACC_WIDTH`, 32: accumulator and output width. Must be at least `DATA_WIDTH*2+4`.
- `FIFO_DEPTH`, 4: output FIFO entries. Power of two, at least 2.

Ports (reset is asynchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `issue_valid`, in, 1: upstream is presenting an operand slice to the dot unit this cycle.
- `issue_last`, in, 1: this slice is the final K-slice of the current output element.
- `issue_ready`, out, 1: block accepts the slice. Fire = `issue_valid & issue_ready`.
- `dot_ena`, out, 1: drives the dot unit's `ena`.
- `dot_res`, in, `DATA_WIDTH*2+4`: signed partial dot product from the dot unit.
- `out_valid`, out, 1: FIFO head holds a finished result.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, `ACC_WIDTH`: finished accumulated result, signed.
- `busy`, out, 1: any tag in flight, accumulation open, or FIFO non-empty.

## Operation
- **Tag pipeline.** `DOT_LATENCY` stages of {valid, last}, advancing only on `dot_ena`. On an advancing edge:
  - stage 0 loads {fire, `issue_last`};
  - stage *i* loads stage *i*-1.
- **Dot enable.** `dot_ena = fire | (any tag stage valid)`.
  - This keeps the dot unit frozen when it is idle.
  - The dot unit and the tag pipeline always advance together.
- **Consume.** When the output tag stage is valid and `dot_ena`=1, `dot_res` is consumed in that cycle:
  - Sign-extend `dot_res` to `ACC_WIDTH`.
  - If no accumulation is open: `sum = ext`. Otherwise: `sum = acc + ext`.
  - If tag.last: push `sum` to the FIFO and close the accumulation (acc value is don't-care).
  - Otherwise: `acc <= sum` and mark the accumulation open.
- **Arithmetic.** Two's-complement wrap at `ACC_WIDTH`. No saturation and no overflow flag.
- **Credits.** `pending = fifo_count + (number of last-tagged valid stages in the tag pipeline)`.
  - `issue_ready = (pending < FIFO_DEPTH)`. Combinational; not a function of `issue_valid`.
  - Invariant: a FIFO push never finds the FIFO full.
- **FIFO.** First-word fall-through.
  - `out_data` = head entry; `out_valid` = non-empty.
  - A simultaneous push and pop in the same cycle leaves the count unchanged. This is allowed at both full and empty.
  - If the FIFO is empty, a push is not forwarded combinationally. It appears the next cycle.
- **Single-slice elements.** An element with `issue_last` on its first slice yields `ext(dot_res)` directly.
- **Reset.** Asserting `rst` at any time (including mid-accumulation or mid-pipeline) clears all tags, the open flag and the FIFO pointers/count. Any partial element is discarded. Upstream must re-issue it.

## Timing
- **Reset values:**
  - `issue_ready`=1;
  - `dot_ena`=0 (with `issue_valid`=0);
  - `out_valid`=0;
  - `busy`=0;
  - `out_data` = 0 (FIFO storage reset to 0).
- **Issue to FIFO.** A last slice fired at edge *t* with continuous `dot_ena` is consumed in the cycle after edge *t*+`DOT_LATENCY`-1. It is visible on `out_data`/`out_valid` after edge *t*+`DOT_LATENCY`.
- **Throughput.** One slice per cycle is sustained while `pending < FIFO_DEPTH`.
- **Credit updates.**
  - A pop frees its credit the cycle after the pop edge.
  - A fire with last consumes its credit at the fire edge.
- **Reset release.** `issue_ready` may be high in the first cycle after `rst` deasserts.

## Test plan
- **Basic accumulation.** `DOT_LATENCY`=3, `out_ready`=1. Issue 4 back-to-back slices; the dot model returns 100, -30, 7, 1 and the 4th slice has last. Required: exactly one `out_data`=78, `out_valid` rising 3 edges after the last fire.
- **Signed extremes.** `DATA_WIDTH`=8. A single last slice returns `dot_res`=20'h80000. Required: `out_data` = 0xFFF80000.
- **Back-pressure and credits.** `FIFO_DEPTH`=4, `out_ready`=0. Issue 6 single-slice elements. Required:
  - `issue_ready` drops after the 4th fire;
  - exactly 4 results are stored, in order, with no loss;
  - raising `out_ready` for 1 cycle re-enables exactly one more issue.
- **Bubbles.** `issue_valid` toggles 1,0,0,1,1 with the last flag on the final slice. Required:
  - `dot_ena` stays high while tags are in flight;
  - the sum equals the three issued results;
  - `dot_ena`=0 once idle.
- **Full-FIFO push/pop.** Fill the FIFO to 3 via credits, then pop and push in the same cycle. Required: `fifo_count` stays 3 and ordering is preserved.
- **Mid-operation reset.** Assert `rst` asynchronously after 2 of 4 slices. Required:
  - all outputs return to reset values immediately;
  - a subsequent 2-slice element returning 5 and 6 yields `out_data`=11, not contaminated by the discarded slices.

Source files
------------

// File: rtl/dot_acc_drain_if.sv
// Handshake bundle between the dot-product drain controller and its surroundings.
// master: the drain controller; slave: operand feeder, dot unit and result writer.
interface dot_acc_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    logic                        issue_valid;
    logic                        issue_last;
    logic                        issue_ready;
    logic                        dot_ena;
    logic [DATA_WIDTH*2+3:0]     dot_res;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_WIDTH-1:0]        out_data;
    logic                        busy;

    modport master (
        input  issue_valid, issue_last, dot_res, out_ready,
        output issue_ready, dot_ena, out_valid, out_data, busy
    );

    modport slave (
        output issue_valid, issue_last, dot_res, out_ready,
        input  issue_ready, dot_ena, out_valid, out_data, busy
    );
endinterface

// File: rtl/dot_acc_drain.sv
// Purpose: drives dot-unit ena, tags slices, accumulates K-slice partials, drains via FWFT FIFO.
// Latency: last slice fired at edge t appears on out_valid/out_data after edge t+DOT_LATENCY.
// Backpressure: credit-based; issue_ready low once FIFO occupancy plus in-flight lasts hits FIFO_DEPTH.
module dot_acc_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int DOT_LATENCY = 1,
    parameter int ACC_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    dot_acc_drain_if.master bus
);
    localparam int RES_WIDTH = DATA_WIDTH*2 + 4;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    tag_t                         tag_q [DOT_LATENCY];
    logic                         open_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q;
    logic [PTR_W-1:0]             rd_ptr_q;
    logic [CNT_W-1:0]             cnt_q;

    logic                         fire;
    logic                         any_tag_vld;
    logic                         consume;
    logic                         push;
    logic                         pop;
    logic [31:0]                  last_inflight;
    logic [31:0]                  pending;
    logic signed [RES_WIDTH-1:0]  res_s;
    logic signed [ACC_WIDTH-1:0]  res_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    tag_t                         tag_out;

    always_comb begin
        any_tag_vld   = 1'b0;
        last_inflight = '0;
        for (int i = 0; i < DOT_LATENCY; i++) begin
            any_tag_vld   = any_tag_vld | tag_q[i].vld;
            last_inflight = last_inflight + 32'(tag_q[i].vld & tag_q[i].last);
        end
    end

    // Every in-flight last already owns a FIFO slot, so a push can never find the FIFO full.
    assign pending         = 32'(cnt_q) + last_inflight;
    assign bus.issue_ready = (pending < 32'(FIFO_DEPTH));
    assign fire            = bus.issue_valid & bus.issue_ready;
    assign bus.dot_ena     = fire | any_tag_vld;

    assign tag_out = tag_q[DOT_LATENCY-1];
    assign consume = tag_out.vld & bus.dot_ena;
    assign push    = consume & tag_out.last;
    assign pop     = bus.out_valid & bus.out_ready;

    assign res_s   = bus.dot_res;
    assign res_ext = ACC_WIDTH'(res_s);
    assign sum     = open_q ? (acc_q + res_ext) : res_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DOT_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (bus.dot_ena) begin
            tag_q[0] <= '{vld: fire, last: bus.issue_last};
            for (int i = 1; i < DOT_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= 1'b0;
            acc_q  <= '0;
        end else if (consume) begin
            if (tag_out.last) begin
                open_q <= 1'b0;
            end else begin
                acc_q  <= sum;
                open_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= sum;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.busy      = any_tag_vld | open_q | bus.out_valid;
endmodule

// File: tb/tb_dot_acc_drain.sv
// Directed bench for dot_acc_drain with a DOT_LATENCY=3 dot-unit model and a 4-deep FIFO.
module tb_dot_acc_drain;
    localparam int DW  = 8;
    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int FD  = 4;

    logic clk;
    logic rst;
    int   issue_val;
    int   n_checks;
    int   n_fail;

    dot_acc_drain_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    dot_acc_drain #(
        .DATA_WIDTH (DW),
        .DOT_LATENCY(LAT),
        .ACC_WIDTH  (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Dot-unit model: the operand's intended result marches through LAT stages on ena.
    logic [19:0] dpipe [LAT];
    initial begin
        for (int i = 0; i < LAT; i++) dpipe[i] = '0;
    end
    always @(posedge clk) begin
        if (bus.dot_ena) begin
            dpipe[0] <= issue_val[19:0];
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign bus.dot_res = dpipe[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        int          res;
        logic        ordy;
        logic        e_rdy;
        logic        e_ena;
        logic        e_ov;
        logic [31:0] e_dat;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic l, input int res, input logic ordy,
                                input logic e_rdy, input logic e_ena, input logic e_ov,
                                input logic [31:0] e_dat, input logic e_busy);
        vec_t x;
        x.v = v; x.l = l; x.res = res; x.ordy = ordy;
        x.e_rdy = e_rdy; x.e_ena = e_ena; x.e_ov = e_ov; x.e_dat = e_dat; x.e_busy = e_busy;
        return x;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input int val, input logic ordy);
        @(negedge clk);
        bus.issue_valid = v;
        bus.issue_last  = l;
        issue_val       = val;
        bus.out_ready   = ordy;
        #1;
    endtask

    int          bp_vals [6];
    int          idx;
    logic [31:0] got[$];
    logic        found;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bp_vals  = '{11, 22, 33, 44, 55, 66};

        // Basic accumulation: 100 - 30 + 7 + 1 = 78, visible 3 edges after the last fire.
        vecs.push_back(mk(1, 0, 100, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, -30, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 7,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 1, 32'd78, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 0, 0));
        // Bubbles: valid 1,0,0,1,1 -> 5 + 9 - 2 = 12.
        vecs.push_back(mk(1, 0, 5,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 9,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, -2,  1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 1, 32'd12, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 0, 0));
        // Signed extreme: 20'h80000 sign-extends to 32'hFFF80000.
        vecs.push_back(mk(1, 1, 32'h80000, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 1, 32'hFFF80000, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 0, 0));

        rst             = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_last  = 1'b0;
        bus.out_ready   = 1'b0;
        issue_val       = 0;
        repeat (3) @(negedge clk);
        #1;
        chk1("reset_issue_ready", bus.issue_ready, 1'b1);
        chk1("reset_dot_ena", bus.dot_ena, 1'b0);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);
        chk32("reset_out_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("release_issue_ready", bus.issue_ready, 1'b1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, vecs[k].l, vecs[k].res, vecs[k].ordy);
            chk1($sformatf("vec%0d_issue_ready", k), bus.issue_ready, vecs[k].e_rdy);
            chk1($sformatf("vec%0d_dot_ena", k), bus.dot_ena, vecs[k].e_ena);
            chk1($sformatf("vec%0d_out_valid", k), bus.out_valid, vecs[k].e_ov);
            chk1($sformatf("vec%0d_busy", k), bus.busy, vecs[k].e_busy);
            if (vecs[k].e_ov) chk32($sformatf("vec%0d_out_data", k), bus.out_data, vecs[k].e_dat);
        end

        // Back-pressure: 4 credits, then one pop releases exactly one more issue.
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b1, bp_vals[idx], 1'b0);
            chk1($sformatf("bp_issue_ready_c%0d", c), bus.issue_ready, (c < 4));
            if (bus.issue_ready && idx < 5) idx++;
        end
        drive(1'b1, 1'b1, bp_vals[idx], 1'b1);
        chk1("bp_full_out_valid", bus.out_valid, 1'b1);
        chk32("bp_head_first", bus.out_data, 32'd11);
        chk1("bp_ready_at_pop", bus.issue_ready, 1'b0);
        drive(1'b1, 1'b1, bp_vals[idx], 1'b0);
        chk1("bp_ready_after_pop", bus.issue_ready, 1'b1);
        chk32("bp_head_second", bus.out_data, 32'd22);
        if (bus.issue_ready && idx < 5) idx++;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, bp_vals[idx], 1'b0);
            chk1($sformatf("bp_reblock_c%0d", c), bus.issue_ready, 1'b0);
        end
        got.delete();
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            drive(idx < 6, 1'b1, bp_vals[(idx < 6) ? idx : 5], 1'b1);
            if (bus.issue_valid && bus.issue_ready) idx++;
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        chk32("bp_drain_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk32($sformatf("bp_drain_%0d", i), got[i], 32'(bp_vals[i+1]));
        drive(1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1);
        chk1("bp_idle_busy", bus.busy, 1'b0);

        // Full-FIFO push/pop: count 3 + one in flight, pop and push on the same edge.
        drive(1'b1, 1'b1, 1, 1'b0);
        drive(1'b1, 1'b1, 2, 1'b0);
        drive(1'b1, 1'b1, 3, 1'b0);
        drive(1'b1, 1'b1, 4, 1'b0);
        chk1("ff_ready_at_3", bus.issue_ready, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk1("ff_blocked_a", bus.issue_ready, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk1("ff_blocked_b", bus.issue_ready, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1);
        chk1("ff_pushpop_ena", bus.dot_ena, 1'b1);
        chk32("ff_pushpop_head", bus.out_data, 32'd1);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk1("ff_count3_ready", bus.issue_ready, 1'b1);
        chk32("ff_head_after", bus.out_data, 32'd2);
        got.delete();
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            drive(1'b0, 1'b0, 0, 1'b1);
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        chk32("ff_drain_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk32($sformatf("ff_drain_%0d", i), got[i], 32'(i + 2));
        drive(1'b0, 1'b0, 0, 1'b1);
        chk1("ff_empty", bus.out_valid, 1'b0);

        // Mid-operation asynchronous reset discards the open element.
        drive(1'b1, 1'b0, 50, 1'b1);
        drive(1'b1, 1'b0, 60, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1);
        chk1("mr_busy_before", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("mr_issue_ready", bus.issue_ready, 1'b1);
        chk1("mr_dot_ena", bus.dot_ena, 1'b0);
        chk1("mr_out_valid", bus.out_valid, 1'b0);
        chk1("mr_busy", bus.busy, 1'b0);
        chk32("mr_out_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 5, 1'b1);
        drive(1'b1, 1'b1, 6, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive(1'b0, 1'b0, 0, 1'b1);
            if (bus.out_valid) begin
                found = 1'b1;
                chk32("mr_result", bus.out_data, 32'd11);
            end
        end
        chk1("mr_result_seen", found, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
